// File: rtl/gate_check_pkg.sv
// rtl/gate_check_pkg.sv - shared types and sizing helpers for the gate truth-table checker
package gate_check_pkg;

  // Checker sequencing: wait for start, settle a vector, sample it, report.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Default geometry (2-input gate); the top recomputes from its own N_IN.
  localparam int N_IN_DEFAULT = 2;
  localparam int NVEC         = 2 ** N_IN_DEFAULT;

  // Number of truth-table rows for an n-input gate.
  function automatic int num_vectors(input int n_in);
    return 2 ** n_in;
  endfunction

  // Settle counter width; one spare bit so the counter can hold SETTLE_CYCLES itself.
  function automatic int settle_cnt_width(input int settle_cycles);
    return $clog2(settle_cycles) + 1;
  endfunction

endpackage

// File: rtl/gate_settle_timer.sv
// rtl/gate_settle_timer.sv - per-vector settle counter with expiry flag
module gate_settle_timer
  import gate_check_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CW            = settle_cnt_width(SETTLE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Count settle cycles while enabled; clear wins so a new vector always starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Expiry is flagged during the last settle cycle so the FSM moves to SAMPLE on that edge.
  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/gate_truth_checker.sv
// rtl/gate_truth_checker.sv - walks all input vectors of a gate and scores its output against a truth table
module gate_truth_checker
  import gate_check_pkg::*;
#(
  parameter int N_IN          = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 dut_q,
  output logic [N_IN-1:0]      dut_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_count,
  output logic [2**N_IN-1:0]   fail_vec
);

  localparam int              NV       = num_vectors(N_IN);
  localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

  state_t          state;
  state_t          state_nxt;
  logic [NV-1:0]   table_q;
  logic            accept;
  logic            timer_clear;
  logic            timer_en;
  logic            expired;
  logic            mismatch;
  logic            last_vec;
  logic [N_IN:0]   err_nxt;

  gate_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (expired)
  );

  // dut_q only matters in SAMPLE; anything it does during SETTLE is ignored.
  assign mismatch = (state == SAMPLE) && (dut_q != table_q[dut_in]);
  assign last_vec = (dut_in == LAST_VEC);
  assign err_nxt  = err_count + {{N_IN{1'b0}}, mismatch};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode; start is only honoured when no run is in progress.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept      = 1'b1;
          timer_clear = 1'b1;
          state_nxt   = SETTLE;
        end
      end
      SETTLE: begin
        timer_en = 1'b1;
        if (expired) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        if (last_vec) begin
          state_nxt = DONE;
        end else begin
          timer_clear = 1'b1;
          state_nxt   = SETTLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Vector stepping, scoreboard and registered status; results hold in DONE until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      table_q   <= '0;
      dut_in    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      busy <= (state_nxt == SETTLE) || (state_nxt == SAMPLE);
      if (accept) begin
        table_q   <= expected;
        dut_in    <= '0;
        err_count <= '0;
        fail_vec  <= '0;
        done      <= 1'b0;
        pass      <= 1'b0;
      end else if (state == SAMPLE) begin
        if (mismatch) begin
          fail_vec[dut_in] <= 1'b1;
          err_count        <= err_nxt;
        end
        if (last_vec) begin
          done <= 1'b1;
          pass <= (err_nxt == '0);
        end else begin
          dut_in <= dut_in + 1'b1;
        end
      end
    end
  end

endmodule
